datapath_exec_pipe: RTL and testbench

DATAPATH_EXEC_PIPE -- requirements
Module: datapath_exec_pipe

---
 rtl/datapath_pkg.sv | 56 +++++
 rtl/alu_core.sv | 64 ++++++
 rtl/datapath_exec_pipe.sv | 139 +++++++++++++
 tb/tb_datapath_exec_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// ============================================================================
// Module  : datapath_pkg
// Brief   : ALU/condition encodings, flag bit positions, condition evaluator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package datapath_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        CC_AL = 3'd0,
        CC_EQ = 3'd1,
        CC_NE = 3'd2,
        CC_LT = 3'd3,
        CC_GE = 3'd4,
        CC_CS = 3'd5,
        CC_CC = 3'd6,
        CC_NV = 3'd7
    } cc_e;

    // Flag register layout is {Z,N,C,V}.
    localparam int c_FLAG_Z = 3;
    localparam int c_FLAG_N = 2;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_V = 0;

    function automatic logic cond_eval(input cc_e cc, input logic [3:0] flags);
        logic r;
        r = 1'b0;
        case (cc)
            CC_AL:   r = 1'b1;
            CC_EQ:   r = flags[c_FLAG_Z];
            CC_NE:   r = !flags[c_FLAG_Z];
            CC_LT:   r = flags[c_FLAG_N] ^ flags[c_FLAG_V];
            CC_GE:   r = !(flags[c_FLAG_N] ^ flags[c_FLAG_V]);
            CC_CS:   r = flags[c_FLAG_C];
            CC_CC:   r = !flags[c_FLAG_C];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module  : alu_core
// Brief   : Combinational ALU producing result and Z/N/C/V.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_core
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             c_o,
    output logic             v_o,
    output logic             z_o,
    output logic             n_o
);

    localparam int c_SW = $clog2(WIDTH);

    alu_op_e          w_op;
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [c_SW-1:0]  w_shamt;

    assign w_op    = alu_op_e'(op_i);
    assign w_sub   = (w_op == ALU_SUB);
    // Subtraction is A + ~B + 1 so carry-out follows the no-borrow convention.
    assign w_b_eff = w_sub ? ~b_i : b_i;
    assign w_sum   = {1'b0, a_i} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    assign w_shamt = b_i[c_SW-1:0];

    always_comb begin
        result_o = '0;
        c_o      = 1'b0;
        v_o      = 1'b0;
        case (w_op)
            ALU_ADD, ALU_SUB: begin
                result_o = w_sum[WIDTH-1:0];
                c_o      = w_sum[WIDTH];
                v_o      = (a_i[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLL: result_o = a_i << w_shamt;
            ALU_SRL: result_o = a_i >> w_shamt;
            ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
    end

    assign z_o = (result_o == '0);
    assign n_o = result_o[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/datapath_exec_pipe.sv
// ============================================================================
// Module  : datapath_exec_pipe
// Brief   : Two-stage execute pipe: regfile read + ALU, then output/commit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module datapath_exec_pipe
    import datapath_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NREG    = 16,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       alu_op_i,
    input  logic             src_b_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [AW-1:0]    r1a_i,
    input  logic [AW-1:0]    r2a_i,
    input  logic [AW-1:0]    wa_i,
    input  logic             rw_i,
    input  logic             fu_i,
    input  logic [2:0]       cc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             perform_o,
    output logic [3:0]       flags_o
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [3:0]       flags_q;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q;
    logic [AW-1:0]    wa_q;
    logic             rw_q;
    logic             fu_q;
    cc_e              cc_q;
    logic [3:0]       sflags_q;

    logic             w_accept, w_commit, w_wr_en;
    logic [WIDTH-1:0] w_op_a, w_rd_b, w_op_b, w_alu_res;
    logic             w_c, w_v, w_z, w_n;
    logic [3:0]       w_new_flags;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_commit   = out_valid_q && out_ready_i;
    assign w_wr_en    = w_commit && rw_q && !((ZERO_R0 != 0) && (wa_q == '0));

    // Hardwired zero takes priority over forwarding from S2.
    always_comb begin
        w_op_a = regs_q[r1a_i];
        if (out_valid_q && rw_q && (wa_q == r1a_i)) w_op_a = result_q;
        if ((ZERO_R0 != 0) && (r1a_i == '0))         w_op_a = '0;
    end

    always_comb begin
        w_rd_b = regs_q[r2a_i];
        if (out_valid_q && rw_q && (wa_q == r2a_i)) w_rd_b = result_q;
        if ((ZERO_R0 != 0) && (r2a_i == '0))         w_rd_b = '0;
    end

    assign w_op_b = src_b_i ? imm_i : w_rd_b;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i      (w_op_a),
        .b_i      (w_op_b),
        .op_i     (alu_op_i),
        .result_o (w_alu_res),
        .c_o      (w_c),
        .v_o      (w_v),
        .z_o      (w_z),
        .n_o      (w_n)
    );

    always_comb begin
        w_new_flags           = '0;
        w_new_flags[c_FLAG_Z] = w_z;
        w_new_flags[c_FLAG_N] = w_n;
        w_new_flags[c_FLAG_C] = w_c;
        w_new_flags[c_FLAG_V] = w_v;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (w_accept)      out_valid_d = 1'b1;
        else if (w_commit) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            wa_q        <= '0;
            rw_q        <= 1'b0;
            fu_q        <= 1'b0;
            cc_q        <= CC_AL;
            sflags_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (w_accept) begin
                result_q <= w_alu_res;
                wa_q     <= wa_i;
                rw_q     <= rw_i;
                fu_q     <= fu_i;
                cc_q     <= cc_e'(cc_i);
                sflags_q <= w_new_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            if (w_commit && fu_q) flags_q <= sflags_q;
            if (w_wr_en)          regs_q[wa_q] <= result_q;
        end
    end

    // Condition sees only flags already committed, never this op's own.
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign flags_o     = flags_q;
    assign perform_o   = out_valid_q && cond_eval(cc_q, flags_q);

endmodule

`default_nettype wire

// File: tb/tb_datapath_exec_pipe.sv
// ============================================================================
// Module  : tb_datapath_exec_pipe
// Brief   : Directed, table-driven self-checking bench for datapath_exec_pipe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_datapath_exec_pipe;

    localparam int c_W = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, src_b, rw, fu, out_valid, out_ready, perform;
    logic [2:0]      alu_op, cc;
    logic [c_W-1:0]  imm, result;
    logic [3:0]      r1a, r2a, wa, flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath_exec_pipe #(
        .WIDTH   (c_W),
        .NREG    (16),
        .ZERO_R0 (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .alu_op_i    (alu_op),
        .src_b_i     (src_b),
        .imm_i       (imm),
        .r1a_i       (r1a),
        .r2a_i       (r2a),
        .wa_i        (wa),
        .rw_i        (rw),
        .fu_i        (fu),
        .cc_i        (cc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .perform_o   (perform),
        .flags_o     (flags)
    );

    typedef struct packed {
        logic [2:0]     op;
        logic           srcb;
        logic [c_W-1:0] imm;
        logic [3:0]     r1, r2, wa;
        logic           rw, fu;
        logic [2:0]     cc;
        logic [c_W-1:0] exp_res;
        logic           exp_perf;
        logic [3:0]     exp_flags;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op_v, input logic srcb_v, input logic [c_W-1:0] imm_v,
                         input logic [3:0] r1_v, input logic [3:0] r2_v, input logic [3:0] wa_v,
                         input logic rw_v, input logic fu_v, input logic [2:0] cc_v);
        alu_op = op_v; src_b = srcb_v; imm = imm_v; r1a = r1_v; r2a = r2_v;
        wa = wa_v; rw = rw_v; fu = fu_v; cc = cc_v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // op: ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SLT7; cc: AL0 EQ1 NE2 LT3 GE4 CS5 CC6 NV7
        // flags {Z,N,C,V} are the committed flags visible while this op sits in S2
        //          op  sb imm      r1 r2 wa rw fu cc  res      perf flags
        vt[0]  = '{3'd0, 1, 16'h0005, 1, 0, 1, 1, 0, 0, 16'h0005, 1, 4'b0000};
        vt[1]  = '{3'd1, 1, 16'h0005, 1, 0, 2, 1, 1, 0, 16'h0000, 1, 4'b0000};
        vt[2]  = '{3'd0, 1, 16'h7FFF, 0, 0, 3, 1, 0, 1, 16'h7FFF, 1, 4'b1010};
        vt[3]  = '{3'd0, 1, 16'h0001, 3, 0, 4, 1, 1, 2, 16'h8000, 0, 4'b1010};
        vt[4]  = '{3'd1, 1, 16'h0001, 0, 0, 5, 1, 1, 3, 16'hFFFF, 0, 4'b0101};
        vt[5]  = '{3'd2, 0, 16'h0000, 4, 5, 6, 1, 0, 3, 16'h8000, 1, 4'b0100};
        vt[6]  = '{3'd3, 1, 16'h0A00, 1, 0, 7, 1, 0, 4, 16'h0A05, 0, 4'b0100};
        vt[7]  = '{3'd4, 1, 16'h00FF, 5, 0, 8, 1, 1, 6, 16'hFF00, 1, 4'b0100};
        vt[8]  = '{3'd0, 1, 16'hABCD, 0, 0, 0, 1, 0, 5, 16'hABCD, 0, 4'b0100};
        vt[9]  = '{3'd3, 1, 16'h0000, 0, 0, 9, 1, 1, 7, 16'h0000, 0, 4'b0100};
        vt[10] = '{3'd5, 1, 16'h0011, 1, 0,10, 1, 0, 1, 16'h000A, 1, 4'b1000};
        vt[11] = '{3'd6, 1, 16'h000F, 4, 0,11, 1, 1, 0, 16'h0001, 1, 4'b1000};
        vt[12] = '{3'd7, 0, 16'h0000, 4, 1,12, 1, 0, 2, 16'h0001, 1, 4'b0000};
        vt[13] = '{3'd7, 0, 16'h0000, 1, 4,13, 1, 1, 4, 16'h0000, 1, 4'b0000};
        vt[14] = '{3'd1, 1, 16'h0001, 4, 0,14, 1, 1, 5, 16'h7FFF, 0, 4'b1000};
        vt[15] = '{3'd0, 0, 16'h0000,14,14,15, 1, 0, 5, 16'hFFFE, 1, 4'b0011};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(3'd0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 3'd0);
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_flags",     {28'd0, flags},     32'd0);
        chk("reset_perform",   {31'd0, perform},   32'd0);
        rst_n = 1'b1;
        #1 chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // One op at a time through the table; each commits before the next.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vt[i].op, vt[i].srcb, vt[i].imm, vt[i].r1, vt[i].r2, vt[i].wa,
                  vt[i].rw, vt[i].fu, vt[i].cc);
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i),   {31'd0, out_valid},     32'd1);
            chk($sformatf("vec%0d_result", i),  {16'd0, result},        {16'd0, vt[i].exp_res});
            chk($sformatf("vec%0d_perform", i), {31'd0, perform},       {31'd0, vt[i].exp_perf});
            chk($sformatf("vec%0d_flags", i),   {28'd0, flags},         {28'd0, vt[i].exp_flags});
        end
        @(negedge clk);
        chk("table_drain_valid", {31'd0, out_valid}, 32'd0);

        // Back-to-back dependent increments through the S2 forward path.
        drive(3'd0, 1'b1, 16'h0001, 4'd13, 4'd0, 4'd13, 1'b1, 1'b0, 3'd0);
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d_valid", k),    {31'd0, out_valid}, 32'd1);
            chk($sformatf("b2b%0d_in_ready", k), {31'd0, in_ready},  32'd1);
            chk($sformatf("b2b%0d_result", k),   {16'd0, result},    k);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Stall: S2 held with out_ready low, nothing commits.
        drive(3'd0, 1'b1, 16'h0001, 4'd13, 4'd0, 4'd13, 1'b1, 1'b1, 3'd5);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        drive(3'd0, 1'b1, 16'd100, 4'd13, 4'd0, 4'd14, 1'b1, 1'b0, 3'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_in_ready", k), {31'd0, in_ready},  32'd0);
            chk($sformatf("stall%0d_valid", k),    {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d_result", k),   {16'd0, result},    32'd9);
            chk($sformatf("stall%0d_flags", k),    {28'd0, flags},     32'h3);
            chk($sformatf("stall%0d_perform", k),  {31'd0, perform},   32'd1);
        end
        out_ready = 1'b1;
        #1 chk("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_next_result",  {16'd0, result},  32'd109);
        chk("stall_next_flags",   {28'd0, flags},   32'd0);
        chk("stall_next_perform", {31'd0, perform}, 32'd0);
        @(negedge clk);

        // r0 is hardwired: a pending write to r0 must not forward.
        drive(3'd0, 1'b1, 16'h1234, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 3'd0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("r0_write_result", {16'd0, result}, 32'h1234);
        drive(3'd3, 1'b1, 16'h0000, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 3'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("r0_no_forward", {16'd0, result}, 32'd0);
        @(negedge clk);

        // Reset while S2 holds a write to r4: discarded, regfile cleared.
        drive(3'd0, 1'b1, 16'h0055, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 3'd0);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("held_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid",   {31'd0, out_valid}, 32'd0);
        chk("async_rst_perform", {31'd0, perform},   32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_ignores_inputs", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd3, 1'b1, 16'h0000, 4'd4, 4'd0, 4'd5, 1'b1, 1'b0, 3'd0);
        #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("r4_cleared",     {16'd0, result},    32'd0);
        chk("post_rst_flags", {28'd0, flags},     32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
